// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_pkg;

  localparam int RETRY_W = 8;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the downstream reset; retries on timeout or loss of lock.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES         = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_reset_n,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [1:0]         state
);

  localparam int MAX_CYC = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Terminal values: a phase of N cycles ends on the edge after count N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt;
  logic               locked_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      lock_lost <= 1'b0;
      unique case (state_q)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_q <= WAIT_LOCK;
            pll_rst <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock is checked first so a coincident timeout never forces a retry.
          if (locked_s) begin
            state_q <= STABLE;
            cnt     <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state_q <= PLL_RST;
            pll_rst <= 1'b1;
            cnt     <= '0;
            if (retry_count != '1) retry_count <= retry_count + RETRY_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt     <= '0;
          end else if (cnt == STABLE_LAST) begin
            state_q     <= RUN;
            sys_reset_n <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q     <= PLL_RST;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            lock_lost   <= 1'b1;
            cnt         <= '0;
            if (retry_count != '1) retry_count <= retry_count + RETRY_W'(1);
          end
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: hand-derived vector table, corner sequences,
// and randomized lock patterns checked against a dwell-time reference model.
module tb_pll_reset_seq;

  localparam int RST_CYC = 4;
  localparam int TO_CYC  = 20;
  localparam int ST_CYC  = 8;
  localparam int SYNC    = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .PLL_RST_CYCLES      (RST_CYC),
    .LOCK_TIMEOUT_CYCLES (TO_CYC),
    .LOCK_STABLE_CYCLES  (ST_CYC),
    .SYNC_STAGES         (SYNC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .state       (state)
  );

  typedef struct packed {
    logic       locked;
    logic [1:0] st;
    logic       prst;
    logic       sysn;
    logic       lost;
    logic [7:0] retry;
  } vec_t;

  vec_t vecs [1:20];

  function automatic logic [12:0] pack(input logic [1:0] st, input logic prst,
                                       input logic sysn, input logic lost,
                                       input logic [7:0] retry);
    return {st, prst, sysn, lost, retry};
  endfunction

  function automatic logic [12:0] dut_bundle();
    return pack(state, pll_rst, sys_reset_n, lock_lost, retry_count);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus edges spent in it, lock seen through a delay line.
  int unsigned m_phase;
  int unsigned m_dwell;
  int unsigned m_retry;
  bit          m_lost;
  bit          sync_q[$];

  task automatic model_reset();
    m_phase = 0;
    m_dwell = 0;
    m_retry = 0;
    m_lost  = 1'b0;
    sync_q  = {};
    repeat (SYNC) sync_q.push_back(1'b0);
  endtask

  task automatic enter(input int unsigned p);
    m_phase = p;
    m_dwell = 0;
  endtask

  task automatic model_step();
    bit ls;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ls = sync_q.pop_front();
    sync_q.push_back(pll_locked);
    m_lost = 1'b0;
    m_dwell++;
    case (m_phase)
      0: if (m_dwell >= RST_CYC) enter(1);
      1: begin
        if (ls) enter(2);
        else if (m_dwell >= TO_CYC) begin
          enter(0);
          if (m_retry < 255) m_retry++;
        end
      end
      2: begin
        if (!ls) enter(1);
        else if (m_dwell >= ST_CYC) enter(3);
      end
      default: begin
        if (!ls) begin
          enter(0);
          m_lost = 1'b1;
          if (m_retry < 255) m_retry++;
        end
      end
    endcase
  endtask

  function automatic logic [12:0] model_bundle();
    return pack(2'(m_phase), m_phase == 0, m_phase == 3, m_lost, 8'(m_retry));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", 32'(dut_bundle()), 32'(model_bundle()));
  endtask

  // Asserts reset away from any clock edge, checks the forced values, releases.
  task automatic do_reset(input string name);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk(name, 32'(dut_bundle()), 32'(pack(2'd0, 1'b1, 1'b0, 1'b0, 8'd0)));
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b1;
    pll_locked = 1'b0;
    #1;
    do_reset("reset_initial");

    // Normal bring-up: lock rises after edge 6, RUN on the 11th edge after.
    for (int i = 1; i <= 20; i++) begin
      vecs[i].locked = (i >= 7);
      vecs[i].st     = (i < 4) ? 2'd0 : (i < 9) ? 2'd1 : (i < 17) ? 2'd2 : 2'd3;
      vecs[i].prst   = (i < 4);
      vecs[i].sysn   = (i >= 17);
      vecs[i].lost   = 1'b0;
      vecs[i].retry  = 8'd0;
    end
    for (int i = 1; i <= 20; i++) begin
      pll_locked = vecs[i].locked;
      tick();
      chk($sformatf("bringup_e%0d", i), 32'(dut_bundle()),
          32'(pack(vecs[i].st, vecs[i].prst, vecs[i].sysn, vecs[i].lost, vecs[i].retry)));
    end

    // Sub-cycle low glitch in RUN, never sampled.
    pll_locked = 1'b0;
    #2;
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("glitch_run_state", 32'(state), 32'd3);

    // Loss of lock in RUN.
    pll_locked = 1'b0;
    tick();
    tick();
    chk("loss_e2_still_run", 32'(state), 32'd3);
    tick();
    chk("loss_e3", 32'(dut_bundle()), 32'(pack(2'd0, 1'b1, 1'b0, 1'b1, 8'd1)));
    tick();
    chk("loss_e4_pulse_end", 32'(dut_bundle()), 32'(pack(2'd0, 1'b1, 1'b0, 1'b0, 8'd1)));

    // Reset asserted mid-STABLE.
    do_reset("reset_pre_stable");
    pll_locked = 1'b1;
    repeat (6) tick();
    chk("midstable_in_stable", 32'(state), 32'd2);
    do_reset("reset_mid_stable");
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("midstable_no_pulse", 32'(lock_lost), 32'd0);

    // Unstable lock: high 5, low 1, high again.
    do_reset("reset_unstable");
    for (int e = 1; e <= 21; e++) begin
      pll_locked = ((e >= 5) && (e <= 9)) || (e >= 11);
      tick();
      if (e == 12) chk("unstable_back_wait", 32'(state), 32'd1);
      if (e == 13) chk("unstable_relock", 32'(state), 32'd2);
      if (e == 20) chk("unstable_still_stable", 32'(state), 32'd2);
      if (e == 21) chk("unstable_run", 32'(dut_bundle()), 32'(pack(2'd3, 1'b0, 1'b1, 1'b0, 8'd0)));
    end

    // Lock seen on the same edge the timeout expires.
    do_reset("reset_simul");
    for (int e = 1; e <= 24; e++) begin
      pll_locked = (e >= 22);
      tick();
      if (e == 23) chk("simul_wait", 32'(state), 32'd1);
      if (e == 24) chk("simul_lock_wins", 32'(dut_bundle()), 32'(pack(2'd2, 1'b0, 1'b0, 1'b0, 8'd0)));
    end

    // Timeout retries with lock held low.
    do_reset("reset_timeout");
    pll_locked = 1'b0;
    for (int e = 1; e <= 72; e++) begin
      tick();
      if (e == 23) chk("timeout_low_e23", 32'(pll_rst), 32'd0);
      if (e == 27) chk("timeout_high_e27", 32'(pll_rst), 32'd1);
      if (e == 28) chk("timeout_low_e28", 32'(pll_rst), 32'd0);
      if (e % 24 == 0) begin
        chk($sformatf("timeout_retry_e%0d", e), 32'(retry_count), 32'(e / 24));
        chk($sformatf("timeout_prst_e%0d", e), 32'(pll_rst), 32'd1);
      end
    end

    // Saturation.
    repeat (300 * (RST_CYC + TO_CYC)) tick();
    chk("saturate_retry", 32'(retry_count), 32'd255);

    // Randomized lock patterns with occasional glitches and resets.
    do_reset("reset_random");
    for (int r = 0; r < 200; r++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 39) == 0) do_reset("reset_random_mid");
      for (int k = 0; k < len; k++) begin
        pll_locked = lvl;
        if ($urandom_range(0, 15) == 0) begin
          pll_locked = ~lvl;
          #2;
          pll_locked = lvl;
        end
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: cycles the PLL reset output is held high per attempt.
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 50000: cycles allowed in WAIT_LOCK before retrying.
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before reset release.
REQ-004 Parameter SYNC_STAGES, default 2, legal range 2..4: flop depth of the lock synchronizer.
REQ-005 Port clk, input, 1: free-running reference clock, the same 50 MHz clock that feeds the PLL refclk.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset for the whole block.
REQ-007 Port pll_locked, input, 1: PLL locked flag, asynchronous to clk.
REQ-008 Port pll_rst, output, 1: active-high reset driven to the PLL rst input.
REQ-009 Port sys_reset_n, output, 1: active-low reset for logic clocked by the PLL outputs; high only in RUN.
REQ-010 Port lock_lost, output, 1: single-cycle pulse when lock is lost in RUN.
REQ-011 Port retry_count, output, 8: saturating count of PLL reset retries since reset_n.
REQ-012 Port state, output, 2: current FSM state encoding.

Function
REQ-013 pll_locked SHALL pass through a SYNC_STAGES flop chain; locked_s is the last stage, and the FSM uses only locked_s.
REQ-014 FSM states SHALL be: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.
REQ-015 PLL_RST: pll_rst=1; a counter counts PLL_RST_CYCLES cycles, then the FSM moves to WAIT_LOCK and clears the counter.
REQ-016 WAIT_LOCK: pll_rst=0; locked_s=1 moves the FSM to STABLE on that edge and clears the counter; a counter reaching LOCK_TIMEOUT_CYCLES moves it to PLL_RST and increments retry_count.
REQ-017 STABLE: the counter increments each cycle locked_s=1, and the transition to RUN occurs on the edge the count reaches LOCK_STABLE_CYCLES.
REQ-018 STABLE: locked_s=0 returns the FSM to WAIT_LOCK with the counter cleared, so the timeout restarts; no retry increment.
REQ-019 RUN: locked_s=0 moves the FSM to PLL_RST, pulses lock_lost for exactly 1 cycle, and increments retry_count.
REQ-020 All outputs SHALL be registered and change on the same edge as the corresponding state transition; sys_reset_n=1 iff the registered state is RUN.
REQ-021 retry_count SHALL saturate at 255 and never wrap; only reset_n clears it.
REQ-022 One shared counter SHALL be sized to clog2 of the largest of the three cycle parameters plus 1; it is cleared on every state change.
REQ-023 A pll_locked glitch shorter than 1 clk period that is not captured by the synchronizer SHALL have no effect; a captured glitch follows REQ-018 or REQ-019.
REQ-024 Simultaneous timeout and locked_s=1 in WAIT_LOCK: locked_s wins, and the FSM goes to STABLE.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state=PLL_RST, pll_rst=1, sys_reset_n=0, lock_lost=0, retry_count=0, counter=0, all synchronizer flops=0.
REQ-026 On reset_n release, counting SHALL begin on the first clk edge.
REQ-027 reset_n asserted mid-operation, in any state, SHALL abort the sequence immediately, with no lock_lost pulse.

Structure
REQ-028 Package pll_reset_pkg SHALL hold the state enum and the retry_count width constant (8).
REQ-029 The synchronizer SHALL be a separate sub-module bit_sync, parameterised by SYNC_STAGES, with an async active-low reset to 0.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, SYNC_STAGES=2)
REQ-030 Normal bring-up: release reset_n, then raise pll_locked 6 cycles later -> pll_rst high exactly 4 cycles; sys_reset_n rises on the 11th clk edge after pll_locked rises; retry_count=0.
REQ-031 Timeout: pll_locked held 0 -> pll_rst re-pulses every 24 cycles (4 high, 20 low); retry_count=1,2,3,...
REQ-032 Unstable lock: pll_locked high 5 cycles, low 1, then high -> FSM returns to WAIT_LOCK, RUN reached 8 counted cycles after re-lock, retry_count=0.
REQ-033 Loss in RUN: drop pll_locked -> lock_lost high exactly 1 cycle, sys_reset_n low and pll_rst high on the same edge, 3 edges after the drop; retry_count increments by 1.
REQ-034 Saturation: 300 timeouts -> retry_count stays at 255.
REQ-035 Mid-STABLE reset: assert reset_n during STABLE -> all outputs take their REQ-025 values with no clk edge, and lock_lost stays 0.
